// File: rtl/mem_stage.sv
// Memory stage: holds one op, waits MEM_WAIT cycles for loads/stores, then
// performs the data-memory access and registers the register-file write.
module mem_stage #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] alu_res,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg,
  input  logic        reg_wrenable,
  input  logic        mem_wrenable,
  input  logic        mem_to_reg,
  input  logic        is_link,
  input  logic        flush,
  output logic        wb_valid,
  output logic        wb_enable,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_reg,
  output logic [31:0] fwd_data,
  output logic        load_pending
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [2:0]         cnt;
  logic [31:0]        h_alu;
  logic [31:0]        h_wdata;
  logic [4:0]         h_wreg;
  logic               h_regwe;
  logic               h_memwe;
  logic               h_m2r;
  logic               h_link;
  logic               capture;
  logic               complete;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        mem [DEPTH];

  assign capture  = in_valid && in_ready && !flush;
  assign complete = (state == BUSY) && (cnt == 3'd0) && !flush;
  assign addr     = h_alu[ADDR_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: flush beats a capture, a capture beats a plain completion
  always_comb begin
    state_nxt = state;
    if (flush)         state_nxt = IDLE;
    else if (capture)  state_nxt = BUSY;
    else if (complete) state_nxt = IDLE;
  end

  // Handshake, forwarding and hazard outputs from the held op
  always_comb begin
    in_ready     = (state == IDLE) || (cnt == 3'd0);
    fwd_valid    = (state == BUSY) && h_regwe && !h_m2r && (h_wreg != 5'd0);
    fwd_reg      = h_wreg;
    fwd_data     = h_link ? h_wdata : h_alu;
    load_pending = (state == BUSY) && h_m2r;
  end

  // Held op and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 3'd0;
      h_alu   <= '0;
      h_wdata <= '0;
      h_wreg  <= '0;
      h_regwe <= 1'b0;
      h_memwe <= 1'b0;
      h_m2r   <= 1'b0;
      h_link  <= 1'b0;
    end else if (flush) begin
      cnt <= 3'd0;
    end else if (capture) begin
      cnt     <= (mem_wrenable || mem_to_reg) ? 3'(MEM_WAIT) : 3'd0;
      h_alu   <= alu_res;
      h_wdata <= write_data;
      h_wreg  <= write_reg;
      h_regwe <= reg_wrenable;
      h_memwe <= mem_wrenable;
      h_m2r   <= mem_to_reg;
      h_link  <= is_link;
    end else if ((state == BUSY) && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Memory access and write-back register; a load sees the pre-write word
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wb_valid  <= 1'b0;
      wb_enable <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
    end else begin
      wb_valid  <= complete;
      wb_enable <= complete && h_regwe && (h_wreg != 5'd0);
      if (complete) begin
        wb_reg  <= h_wreg;
        wb_data <= h_m2r ? mem[addr] : (h_link ? h_wdata : h_alu);
        if (h_memwe) mem[addr] <= h_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, directed corner sequences, and random
// traffic against a transaction-level reference model (MEM_WAIT=1 and 3).
module tb_mem_stage;

  localparam int unsigned W1 = 1;
  localparam int unsigned W3 = 3;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        regwe;
    logic        memwe;
    logic        m2r;
    logic        link;
  } op_t;

  typedef struct {
    op_t         op;
    logic [31:0] exp_data;
    logic        exp_en;
    logic        exp_fwd;
    logic [31:0] exp_fwd_data;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rst3 = 1'b1;
  logic        in_valid = 1'b0, in_valid3 = 1'b0, flush = 1'b0, flush3 = 1'b0;
  logic [31:0] alu_res = '0, write_data = '0;
  logic [4:0]  write_reg = '0;
  logic        reg_wrenable = 1'b0, mem_wrenable = 1'b0, mem_to_reg = 1'b0, is_link = 1'b0;

  logic        in_ready, wb_valid, wb_enable, fwd_valid, load_pending;
  logic [4:0]  wb_reg, fwd_reg;
  logic [31:0] wb_data, fwd_data;
  logic        in_ready3, wb_valid3, wb_enable3, fwd_valid3, load_pending3;
  logic [4:0]  wb_reg3, fwd_reg3;
  logic [31:0] wb_data3, fwd_data3;

  mem_stage #(.ADDR_W(5), .MEM_WAIT(W1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_res(alu_res), .write_data(write_data), .write_reg(write_reg),
    .reg_wrenable(reg_wrenable), .mem_wrenable(mem_wrenable),
    .mem_to_reg(mem_to_reg), .is_link(is_link), .flush(flush),
    .wb_valid(wb_valid), .wb_enable(wb_enable), .wb_reg(wb_reg), .wb_data(wb_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .load_pending(load_pending)
  );

  mem_stage #(.ADDR_W(5), .MEM_WAIT(W3)) u_dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .alu_res(alu_res), .write_data(write_data), .write_reg(write_reg),
    .reg_wrenable(reg_wrenable), .mem_wrenable(mem_wrenable),
    .mem_to_reg(mem_to_reg), .is_link(is_link), .flush(flush3),
    .wb_valid(wb_valid3), .wb_enable(wb_enable3), .wb_reg(wb_reg3), .wb_data(wb_data3),
    .fwd_valid(fwd_valid3), .fwd_reg(fwd_reg3), .fwd_data(fwd_data3),
    .load_pending(load_pending3)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input op_t o);
    alu_res      = o.alu;
    write_data   = o.wd;
    write_reg    = o.wr;
    reg_wrenable = o.regwe;
    mem_wrenable = o.memwe;
    mem_to_reg   = o.m2r;
    is_link      = o.link;
  endtask

  // One op on the MEM_WAIT=1 instance, from idle to its write-back pulse
  task automatic run_vec(input vec_t v);
    int  lat;
    bit  found;
    @(negedge clk);
    chk1("ready_idle", in_ready, 1'b1);
    drive(v.op);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("fwd_valid", fwd_valid, v.exp_fwd);
    if (v.exp_fwd) begin
      chk32("fwd_data", fwd_data, v.exp_fwd_data);
      chk32("fwd_reg", 32'(fwd_reg), 32'(v.op.wr));
    end
    chk1("load_pending", load_pending, v.op.m2r);
    chk1("ready_held", in_ready, !(v.op.memwe || v.op.m2r));
    lat = 0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (wb_valid) found = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk1("wb_seen", found, 1'b1);
    chk32("wb_latency", 32'(lat), (v.op.memwe || v.op.m2r) ? 32'(W1 + 1) : 32'd1);
    chk32("wb_data", wb_data, v.exp_data);
    chk32("wb_reg", 32'(wb_reg), 32'(v.op.wr));
    chk1("wb_enable", wb_enable, v.exp_en);
    @(negedge clk);
    chk1("wb_pulse_end", wb_valid, 1'b0);
    chk1("wb_en_low", wb_enable, 1'b0);
  endtask

  // Reference model: held op completes at an absolute edge number
  logic [31:0] m_mem [32];
  bit          m_held;
  op_t         m_op;
  int          m_done, edge_no;
  logic        e_wb_valid, e_wb_enable;
  logic [4:0]  e_wb_reg;
  logic [31:0] e_wb_data;

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = '0;
    m_held = 1'b0; m_op = '0; m_done = 0; edge_no = 0;
    e_wb_valid = 1'b0; e_wb_enable = 1'b0; e_wb_reg = '0; e_wb_data = '0;
  endtask

  task automatic model_step(input logic iv, input logic fl, input op_t o);
    int e;
    bit rdy, comp;
    e    = edge_no + 1;
    rdy  = !m_held || (e == m_done);
    comp = m_held && (e == m_done) && !fl;
    e_wb_valid  = comp;
    e_wb_enable = comp && m_op.regwe && (m_op.wr != 5'd0);
    if (comp) begin
      e_wb_reg  = m_op.wr;
      e_wb_data = m_op.m2r ? m_mem[m_op.alu[4:0]] : (m_op.link ? m_op.wd : m_op.alu);
      if (m_op.memwe) m_mem[m_op.alu[4:0]] = m_op.wd;
    end
    if (fl) m_held = 1'b0;
    else if (iv && rdy) begin
      m_held = 1'b1;
      m_op   = o;
      m_done = e + ((o.memwe || o.m2r) ? int'(W1) : 0) + 1;
    end else if (comp) m_held = 1'b0;
    edge_no = e;
  endtask

  task automatic model_check();
    logic ef;
    ef = m_held && m_op.regwe && !m_op.m2r && (m_op.wr != 5'd0);
    chk1("r_in_ready", in_ready, !m_held || (edge_no + 1 == m_done));
    chk1("r_wb_valid", wb_valid, e_wb_valid);
    chk1("r_wb_enable", wb_enable, e_wb_enable);
    chk32("r_wb_reg", 32'(wb_reg), 32'(e_wb_reg));
    chk32("r_wb_data", wb_data, e_wb_data);
    chk1("r_fwd_valid", fwd_valid, ef);
    if (ef) begin
      chk32("r_fwd_reg", 32'(fwd_reg), 32'(m_op.wr));
      chk32("r_fwd_data", fwd_data, m_op.link ? m_op.wd : m_op.alu);
    end
    chk1("r_load_pending", load_pending, m_held && m_op.m2r);
  endtask

  vec_t vecs [7];
  vec_t v;
  op_t  o;
  int   lat3;
  bit   seen3;

  initial begin
    vecs[0] = '{'{32'h1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0}, 32'h1234, 1'b1, 1'b1, 32'h1234};
    vecs[1] = '{'{32'h25, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}, 32'h25, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{'{32'h05, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0}, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{'{32'h10, 32'h7, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1}, 32'h7, 1'b1, 1'b1, 32'h7};
    vecs[4] = '{'{32'h55, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0}, 32'h55, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{'{32'h05, 32'h0BADF00D, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0}, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{'{32'h25, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0}, 32'h0BADF00D, 1'b1, 1'b0, 32'h0};

    repeat (2) @(negedge clk);
    rst = 1'b0; rst3 = 1'b0;
    chk1("rst_in_ready", in_ready, 1'b1);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_wb_enable", wb_enable, 1'b0);
    chk32("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk32("rst_wb_data", wb_data, 32'd0);
    chk1("rst_fwd_valid", fwd_valid, 1'b0);
    chk1("rst_load_pending", load_pending, 1'b0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back ALU ops: one per cycle
    @(negedge clk);
    drive('{32'hA, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b1;
    @(negedge clk);
    chk1("b2b_ready", in_ready, 1'b1);
    drive('{32'hB, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    chk1("b2b_wb1_valid", wb_valid, 1'b1);
    chk32("b2b_wb1_data", wb_data, 32'hA);
    chk32("b2b_fwd_data", fwd_data, 32'hB);
    @(negedge clk);
    chk1("b2b_wb2_valid", wb_valid, 1'b1);
    chk32("b2b_wb2_data", wb_data, 32'hB);
    @(negedge clk);
    chk1("b2b_wb_end", wb_valid, 1'b0);

    // Flush on the completion edge of a store to word 2, with an ignored op
    drive('{32'h2, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk1("fl_ready_wait", in_ready, 1'b0);
    @(negedge clk);
    chk1("fl_ready_last", in_ready, 1'b1);
    flush = 1'b1;
    drive('{32'h77, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0});
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk1("fl_no_wb", wb_valid, 1'b0);
    chk1("fl_idle_ready", in_ready, 1'b1);
    chk1("fl_ignored_fwd", fwd_valid, 1'b0);
    @(negedge clk);
    chk1("fl_ignored_wb", wb_valid, 1'b0);
    v = '{'{32'h2, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0}, 32'h0, 1'b1, 1'b0, 32'h0};
    run_vec(v);

    // Reset mid-wait on the MEM_WAIT=3 instance
    @(negedge clk);
    drive('{32'h9, 32'h11111111, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    chk1("w3_ready_0", in_ready3, 1'b0);
    @(negedge clk);
    chk1("w3_ready_1", in_ready3, 1'b0);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk1("w3_rst_ready", in_ready3, 1'b1);
    chk1("w3_rst_wb_valid", wb_valid3, 1'b0);
    chk1("w3_rst_wb_enable", wb_enable3, 1'b0);
    chk32("w3_rst_wb_reg", 32'(wb_reg3), 32'd0);
    chk32("w3_rst_wb_data", wb_data3, 32'd0);
    chk1("w3_rst_fwd", fwd_valid3, 1'b0);
    chk1("w3_rst_lp", load_pending3, 1'b0);
    drive('{32'h9, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0});
    in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    chk1("w3_load_pending", load_pending3, 1'b1);
    lat3 = 0; seen3 = 1'b0;
    for (int k = 0; k < 12 && !seen3; k++) begin
      if (wb_valid3) seen3 = 1'b1;
      else begin
        @(negedge clk);
        lat3++;
      end
    end
    chk1("w3_wb_seen", seen3, 1'b1);
    chk32("w3_latency", 32'(lat3), 32'(W3 + 1));
    chk32("w3_load_data", wb_data3, 32'd0);
    chk1("w3_wb_enable", wb_enable3, 1'b1);

    // Random traffic against the reference model
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      model_check();
      o.alu   = $urandom;
      o.wd    = $urandom;
      o.wr    = 5'($urandom_range(0, 3));
      o.regwe = 1'($urandom);
      o.memwe = ($urandom_range(0, 2) == 0);
      o.m2r   = ($urandom_range(0, 2) == 0);
      o.link  = ($urandom_range(0, 3) == 0);
      drive(o);
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      model_step(in_valid, flush, o);
      @(negedge clk);
    end
    model_check();
    in_valid = 1'b0;
    flush    = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, log2 of data-memory depth in 32-bit words.
REQ-002 SHALL have parameter MEM_WAIT, default 1, extra cycles for any load/store (0..7).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid input 1 (execute result present) and in_ready output 1 (stage accepts this cycle).
REQ-006 SHALL have ports alu_res input 32 (result/address), write_data input 32 (store data or link value), write_reg input 5, reg_wrenable input 1, mem_wrenable input 1, mem_to_reg input 1, is_link input 1 (jal/jalr).
REQ-007 SHALL have port flush  input  1  discard the held op.
REQ-008 SHALL have ports wb_valid output 1, wb_enable output 1, wb_reg output 5 and wb_data output 32, forming the register-file write port.
REQ-009 SHALL have ports fwd_valid output 1, fwd_reg output 5 and fwd_data output 32, carrying the forwarding source.
REQ-010 SHALL have port load_pending  output  1  held op is a load (hazard indication to decode).

Function
REQ-011 SHALL hold one op in state IDLE or BUSY, with a wait counter cnt (3 bits).
REQ-012 SHALL capture all inputs on an edge where in_valid && in_ready && !flush; cnt loads MEM_WAIT if mem_wrenable||mem_to_reg, else 0; state becomes BUSY.
REQ-013 SHALL drive in_ready = (state==IDLE) || (state==BUSY && cnt==0), giving one-op-per-cycle throughput for non-memory ops.
REQ-014 SHALL decrement cnt each BUSY cycle with cnt!=0; the op completes on the BUSY edge where cnt==0.
REQ-015 SHALL, at completion, write write_data to mem[alu_res[ADDR_W-1:0]] if mem_wrenable; upper address bits are ignored, so the address wraps modulo 2^ADDR_W.
REQ-016 SHALL, at completion, register wb_valid=1, wb_reg=write_reg, wb_enable=reg_wrenable && write_reg!=0, and wb_data = mem_to_reg ? mem[addr] (pre-write contents) : is_link ? write_data : alu_res.
REQ-017 SHALL hold wb_valid high for exactly one cycle per completed op; wb_enable SHALL be 0 whenever wb_valid is 0.
REQ-018 SHALL return to IDLE on completion unless a new op is captured on the same edge; a new op captured on that edge takes state BUSY.
REQ-019 SHALL drive fwd_valid = BUSY && reg_wrenable && !mem_to_reg && write_reg!=0, fwd_reg = held write_reg, and fwd_data = is_link ? write_data : alu_res, all from held values.
REQ-020 SHALL drive load_pending = BUSY && held mem_to_reg.
REQ-021 SHALL, when flush=1, go to IDLE with no memory write and no wb_valid for the held op, and ignore in_valid that cycle; flush wins over a simultaneous completion.
REQ-022 SHALL treat mem_wrenable && mem_to_reg both high as a store followed by a load of the old word, in a single access.

Reset
REQ-023 SHALL, on rst, set state IDLE, cnt=0, wb_valid=0, wb_enable=0, wb_reg=0, wb_data=0, fwd_valid=0 and load_pending=0, and clear all memory words to 0.
REQ-024 SHALL give rst priority over flush and in_valid; rst during BUSY discards the op with no memory write.
REQ-025 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-026 Bench SHALL cover ALU op alu_res=0x1234, write_reg=3, reg_wrenable=1 -> wb_valid one cycle later, wb_data=0x1234, wb_reg=3, wb_enable=1; fwd_valid=1 while held.
REQ-027 Bench SHALL cover a store (alu_res=0x25, write_data=0xDEADBEEF) then a load (alu_res=0x05) with MEM_WAIT=1 -> in_ready=0 for one cycle per op; the load returns 0xDEADBEEF because of address wrap; load_pending=1 while the load is held.
REQ-028 Bench SHALL cover jal with is_link=1, write_data=7, alu_res=0x10, write_reg=1 -> wb_data=7.
REQ-029 Bench SHALL cover write_reg=0 with reg_wrenable=1 -> wb_valid=1, wb_enable=0, fwd_valid=0.
REQ-030 Bench SHALL cover flush asserted on the completion edge of a store to word 2 -> no wb_valid; a later load of word 2 returns 0.
REQ-031 Bench SHALL cover rst mid-wait with MEM_WAIT=3 -> all outputs 0 next cycle, in_ready=1, and the store is not performed.
